// File: rtl/i2s_capture_ctrl.sv
// rtl/i2s_capture_ctrl.sv - I2S microphone capture session sequencer with decimation and memory write port
module i2s_capture_ctrl #(
    parameter int DATA_SIZE      = 24,
    parameter int ADDR_WIDTH     = 16,
    parameter int COUNT_WIDTH    = 16,
    parameter int WARMUP_SAMPLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_start,
    input  logic                   cmd_abort,
    input  logic [COUNT_WIDTH-1:0] cmd_len,
    input  logic [ADDR_WIDTH-1:0]  cmd_base,
    input  logic [3:0]             cmd_decim,
    output logic                   cap_en,
    input  logic                   sample_valid,
    input  logic [DATA_SIZE-1:0]   sample_data,
    output logic                   wr_valid,
    output logic [ADDR_WIDTH-1:0]  wr_addr,
    output logic [DATA_SIZE-1:0]   wr_data,
    input  logic                   wr_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   aborted,
    output logic                   overflow,
    output logic [COUNT_WIDTH-1:0] written
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WARMUP,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] WARMUP_INIT = COUNT_WIDTH'(WARMUP_SAMPLES);
    localparam bit                     NO_WARMUP   = (WARMUP_SAMPLES == 0);

    state_t                 state_q;
    logic [COUNT_WIDTH-1:0] len_q;
    logic [COUNT_WIDTH-1:0] warm_q;
    logic [COUNT_WIDTH-1:0] cap_cnt_q;
    logic [COUNT_WIDTH-1:0] written_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_SIZE-1:0]   data_q;
    logic [3:0]             decim_q;
    logic [3:0]             dec_cnt_q;
    logic                   wr_valid_q;
    logic                   cap_en_q;
    logic                   done_q;
    logic                   aborted_q;
    logic                   overflow_q;

    logic accept;
    logic hold_free;

    // The holding register can take a new sample when empty or when it drains this cycle.
    assign accept    = wr_valid_q && wr_ready;
    assign hold_free = !wr_valid_q || wr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            warm_q     <= '0;
            cap_cnt_q  <= '0;
            written_q  <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            decim_q    <= '0;
            dec_cnt_q  <= '0;
            wr_valid_q <= 1'b0;
            cap_en_q   <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                wr_valid_q <= 1'b0;
                addr_q     <= addr_q + ADDR_WIDTH'(1);
                written_q  <= written_q + COUNT_WIDTH'(1);
            end
            case (state_q)
                S_IDLE: begin
                    if (cmd_start && !cmd_abort) begin
                        len_q      <= cmd_len;
                        addr_q     <= cmd_base;
                        decim_q    <= cmd_decim;
                        overflow_q <= 1'b0;
                        aborted_q  <= 1'b0;
                        written_q  <= '0;
                        warm_q     <= WARMUP_INIT;
                        cap_cnt_q  <= '0;
                        dec_cnt_q  <= '0;
                        if (cmd_len == '0) begin
                            state_q <= S_DONE;
                        end else begin
                            cap_en_q <= 1'b1;
                            state_q  <= NO_WARMUP ? S_RUN : S_WARMUP;
                        end
                    end
                end
                S_WARMUP: begin
                    if (cmd_abort) begin
                        state_q    <= S_DONE;
                        cap_en_q   <= 1'b0;
                        wr_valid_q <= 1'b0;
                        aborted_q  <= 1'b1;
                    end else if (sample_valid) begin
                        warm_q <= warm_q - COUNT_WIDTH'(1);
                        if (warm_q == COUNT_WIDTH'(1)) begin
                            state_q   <= S_RUN;
                            dec_cnt_q <= '0;
                        end
                    end
                end
                S_RUN: begin
                    if (cmd_abort) begin
                        state_q    <= S_DONE;
                        cap_en_q   <= 1'b0;
                        wr_valid_q <= 1'b0;
                        aborted_q  <= 1'b1;
                    end else if (sample_valid) begin
                        dec_cnt_q <= (dec_cnt_q == decim_q) ? 4'd0 : dec_cnt_q + 4'd1;
                        if (dec_cnt_q == 4'd0) begin
                            if (hold_free) begin
                                data_q     <= sample_data;
                                wr_valid_q <= 1'b1;
                                cap_cnt_q  <= cap_cnt_q + COUNT_WIDTH'(1);
                                if (cap_cnt_q + COUNT_WIDTH'(1) == len_q) begin
                                    cap_en_q <= 1'b0;
                                    state_q  <= S_DRAIN;
                                end
                            end else begin
                                // Dropped samples do not count toward the session length.
                                overflow_q <= 1'b1;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (cmd_abort) begin
                        state_q    <= S_DONE;
                        cap_en_q   <= 1'b0;
                        wr_valid_q <= 1'b0;
                        aborted_q  <= 1'b1;
                    end else if (hold_free) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cap_en   = cap_en_q;
    assign wr_valid = wr_valid_q;
    assign wr_addr  = addr_q;
    assign wr_data  = data_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign aborted  = aborted_q;
    assign overflow = overflow_q;
    assign written  = written_q;

endmodule

// File: tb/tb_i2s_capture_ctrl.sv
// tb/tb_i2s_capture_ctrl.sv - directed self-checking bench for i2s_capture_ctrl
module tb_i2s_capture_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_start = 1'b0;
    logic        cmd_abort = 1'b0;
    logic [15:0] cmd_len = '0;
    logic [15:0] cmd_base = '0;
    logic [3:0]  cmd_decim = '0;
    logic        cap_en;
    logic        sample_valid = 1'b0;
    logic [23:0] sample_data = '0;
    logic        wr_valid;
    logic [15:0] wr_addr;
    logic [23:0] wr_data;
    logic        wr_ready = 1'b1;
    logic        busy;
    logic        done;
    logic        aborted;
    logic        overflow;
    logic [15:0] written;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] qa[$];
    logic [23:0] qd[$];
    int          done_cnt = 0;
    logic        cap_seen = 1'b0;

    i2s_capture_ctrl #(
        .DATA_SIZE(24), .ADDR_WIDTH(16), .COUNT_WIDTH(16), .WARMUP_SAMPLES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_start(cmd_start), .cmd_abort(cmd_abort),
        .cmd_len(cmd_len), .cmd_base(cmd_base), .cmd_decim(cmd_decim),
        .cap_en(cap_en), .sample_valid(sample_valid), .sample_data(sample_data),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .busy(busy), .done(done), .aborted(aborted), .overflow(overflow), .written(written)
    );

    always #5 clk = ~clk;

    // Pre-edge values are seen here because the design updates with non-blocking assignments.
    always @(posedge clk) begin
        if (rst_n) begin
            if (wr_valid && wr_ready) begin
                qa.push_back(wr_addr);
                qd.push_back(wr_data);
            end
            if (done) done_cnt <= done_cnt + 1;
            if (cap_en) cap_seen <= 1'b1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_start(input logic [15:0] len, input logic [15:0] base, input logic [3:0] decim);
        cmd_start = 1'b1;
        cmd_len   = len;
        cmd_base  = base;
        cmd_decim = decim;
        @(negedge clk);
        cmd_start = 1'b0;
    endtask

    task automatic send(input logic [23:0] d);
        sample_valid = 1'b1;
        sample_data  = d;
        @(negedge clk);
        sample_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic clear_log();
        qa.delete();
        qd.delete();
        done_cnt = 0;
        cap_seen = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_cap_en", 32'(cap_en), 32'd0);
        check_eq("rst_wr_valid", 32'(wr_valid), 32'd0);
        check_eq("rst_written", 32'(written), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic session: two warm-up samples discarded, four stored.
        clear_log();
        do_start(16'd4, 16'h0010, 4'd0);
        check_eq("t1_cap_en", 32'(cap_en), 32'd1);
        for (int i = 0; i < 6; i++) send(24'h000100 + 24'(i));
        repeat (4) @(negedge clk);
        check_eq("t1_nwr", 32'(qa.size()), 32'd4);
        for (int i = 0; i < 4 && i < qa.size(); i++) begin
            check_eq("t1_addr", 32'(qa[i]), 32'h10 + 32'(i));
            check_eq("t1_data", 32'(qd[i]), 32'h102 + 32'(i));
        end
        check_eq("t1_done", 32'(done_cnt), 32'd1);
        check_eq("t1_written", 32'(written), 32'd4);
        check_eq("t1_ovf", 32'(overflow), 32'd0);
        check_eq("t1_busy", 32'(busy), 32'd0);

        // Decimation by 3: D0, D3, D6 kept; cap_en drops when D6 loads.
        clear_log();
        do_start(16'd3, 16'h0020, 4'd2);
        send(24'hAAAAAA);
        send(24'hAAAAAA);
        for (int i = 0; i < 9; i++) begin
            send(24'h000200 + 24'(i));
            if (i == 5) check_eq("t2_cap_en_d5", 32'(cap_en), 32'd1);
            if (i == 6) check_eq("t2_cap_en_d6", 32'(cap_en), 32'd0);
        end
        repeat (3) @(negedge clk);
        check_eq("t2_nwr", 32'(qa.size()), 32'd3);
        for (int i = 0; i < 3 && i < qd.size(); i++)
            check_eq("t2_data", 32'(qd[i]), 32'h200 + 32'(3 * i));
        check_eq("t2_done", 32'(done_cnt), 32'd1);

        // Back-pressure: second kept sample dropped, overflow sticky.
        clear_log();
        wr_ready = 1'b0;
        do_start(16'd2, 16'h0030, 4'd0);
        send(24'h0);
        send(24'h0);
        send(24'h0003A0);
        send(24'h0003B0);
        check_eq("t3_ovf", 32'(overflow), 32'd1);
        repeat (16) @(negedge clk);
        check_eq("t3_hold_valid", 32'(wr_valid), 32'd1);
        check_eq("t3_hold_data", 32'(wr_data), 32'h3A0);
        check_eq("t3_hold_addr", 32'(wr_addr), 32'h30);
        wr_ready = 1'b1;
        @(negedge clk);
        send(24'h0003C0);
        repeat (3) @(negedge clk);
        check_eq("t3_nwr", 32'(qa.size()), 32'd2);
        if (qa.size() == 2) begin
            check_eq("t3_addr1", 32'(qa[1]), 32'h31);
            check_eq("t3_data1", 32'(qd[1]), 32'h3C0);
        end
        check_eq("t3_written", 32'(written), 32'd2);
        check_eq("t3_ovf_hold", 32'(overflow), 32'd1);
        check_eq("t3_done", 32'(done_cnt), 32'd1);

        // Address wrap at the top of the address space.
        clear_log();
        do_start(16'd4, 16'hFFFE, 4'd0);
        check_eq("t4_ovf_cleared", 32'(overflow), 32'd0);
        for (int i = 0; i < 6; i++) send(24'h000400 + 24'(i));
        repeat (3) @(negedge clk);
        check_eq("t4_nwr", 32'(qa.size()), 32'd4);
        if (qa.size() == 4) begin
            check_eq("t4_a0", 32'(qa[0]), 32'hFFFE);
            check_eq("t4_a1", 32'(qa[1]), 32'hFFFF);
            check_eq("t4_a2", 32'(qa[2]), 32'h0000);
            check_eq("t4_a3", 32'(qa[3]), 32'h0001);
        end

        // Abort in RUN with a write pending.
        clear_log();
        do_start(16'd8, 16'h0040, 4'd0);
        for (int i = 0; i < 4; i++) send(24'h000500 + 24'(i));
        wr_ready = 1'b0;
        send(24'h000510);
        check_eq("t5_pending", 32'(wr_valid), 32'd1);
        cmd_abort = 1'b1;
        @(negedge clk);
        cmd_abort = 1'b0;
        check_eq("t5_wr_valid", 32'(wr_valid), 32'd0);
        check_eq("t5_aborted", 32'(aborted), 32'd1);
        check_eq("t5_cap_en", 32'(cap_en), 32'd0);
        @(negedge clk);
        check_eq("t5_done", 32'(done), 32'd1);
        check_eq("t5_written", 32'(written), 32'd2);
        check_eq("t5_nwr", 32'(qa.size()), 32'd2);
        wr_ready = 1'b1;
        @(negedge clk);

        // Zero-length session.
        clear_log();
        do_start(16'd0, 16'h0060, 4'd0);
        check_eq("t5z_done_early", 32'(done), 32'd0);
        check_eq("t5z_aborted_clr", 32'(aborted), 32'd0);
        @(negedge clk);
        check_eq("t5z_done", 32'(done), 32'd1);
        repeat (2) @(negedge clk);
        check_eq("t5z_nwr", 32'(qa.size()), 32'd0);
        check_eq("t5z_cap_seen", 32'(cap_seen), 32'd0);

        // Start while busy, then start+abort in IDLE.
        clear_log();
        do_start(16'd2, 16'h0050, 4'd0);
        send(24'h0);
        send(24'h0);
        send(24'h000600);
        do_start(16'd9, 16'h0099, 4'd3);
        send(24'h000601);
        repeat (3) @(negedge clk);
        check_eq("t6_nwr", 32'(qa.size()), 32'd2);
        if (qa.size() == 2) check_eq("t6_addr1", 32'(qa[1]), 32'h51);
        check_eq("t6_written", 32'(written), 32'd2);
        cmd_abort = 1'b1;
        do_start(16'd5, 16'h0070, 4'd0);
        cmd_abort = 1'b0;
        check_eq("t6_sa_busy", 32'(busy), 32'd0);
        check_eq("t6_sa_cap_en", 32'(cap_en), 32'd0);
        check_eq("t6_sa_written", 32'(written), 32'd2);
        check_eq("t6_sa_aborted", 32'(aborted), 32'd0);

        // Asynchronous reset mid-session.
        do_start(16'd3, 16'h0080, 4'd0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t7_rst_busy", 32'(busy), 32'd0);
        check_eq("t7_rst_cap_en", 32'(cap_en), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
